q_add_pipe: RTL and testbench
=============================

Q_ADD_PIPE -- requirements
Module: q_add_pipe

Interface
REQ-001 Parameter DW, default 8: signed data width of A_IN, B_IN, C_OUT, MIN, MAX.
REQ-002 Parameter GW, default 16: signed width of GAIN.
REQ-003 Parameter QW, default 16: signed width of Q_PARAM.
REQ-004 Parameter GFRAC, default 8: fractional bits of GAIN.
REQ-005 Parameter QFRAC, default 8: fractional bits of Q_PARAM.
REQ-006 CLK  in  1  single clock; all state updates on its rising edge.
REQ-007 RESET  in  1  reset, asynchronous and active-high.
REQ-008 INPUT_EN  in  1  input sample valid.
REQ-009 OP_SEL  in  1  0 = add, 1 = subtract; sampled with the data.
REQ-010 A_IN, B_IN  in  DW  signed operands.
REQ-011 GAIN  in  GW  signed gain applied to B; sampled with the data.
REQ-012 Q_PARAM  in  QW  signed requantisation scale; sampled with the data.
REQ-013 STAT_CLR  in  1  synchronous clear of the statistics.
REQ-014 OUTPUT_EN  out  1  C_OUT valid.
REQ-015 C_OUT  out  DW  signed saturated result.
REQ-016 MIN, MAX  out  DW  signed running extrema of valid outputs.
REQ-017 STAT_VALID  out  1  at least one output has been recorded since reset or clear.
REQ-018 SAT_CNT  out  16  count of saturated outputs.

Function
REQ-019 The block SHALL compute C = sat_DW(round((B*GAIN ± (A << GFRAC)) * Q_PARAM >> (GFRAC+QFRAC))), with '-' when OP_SEL=1.
REQ-020 All arithmetic SHALL be two's-complement signed at full precision, with no intermediate truncation: the sum is DW+GW+1 bits and the product is DW+GW+QW+1 bits.
REQ-021 Rounding SHALL be round-half-up: add 2^(GFRAC+QFRAC-1), then arithmetic right shift.
REQ-022 Saturation SHALL clamp to [-2^(DW-1), 2^(DW-1)-1].
REQ-023 Pipeline stages:
 - S1: register inputs, OP_SEL, GAIN, Q_PARAM.
 - S2: B*GAIN.
 - S3: add or subtract the aligned A.
 - S4: multiply by Q_PARAM.
 - S5: round, saturate and register C_OUT.
REQ-024 Latency SHALL be exactly 5 cycles: INPUT_EN high at edge n gives OUTPUT_EN high after edge n+5.
REQ-025 The block SHALL accept one sample per cycle, with no stall and no back-pressure.
REQ-026 The valid bit SHALL travel alongside the data in every stage.
REQ-027 GAIN, Q_PARAM and OP_SEL SHALL be per-sample: a change takes effect on the next accepted sample only, never on samples already in flight.
REQ-028 C_OUT SHALL hold its last value when OUTPUT_EN is low.
REQ-029 On each OUTPUT_EN cycle the block SHALL update MIN/MAX with C_OUT using signed comparison and set STAT_VALID.
REQ-030 SAT_CNT SHALL increment on each valid output that clamped, and SHALL stick at 0xFFFF.
REQ-031 STAT_CLR SHALL set MIN=2^(DW-1)-1, MAX=-2^(DW-1), STAT_VALID=0 and SAT_CNT=0.
REQ-032 STAT_CLR coinciding with OUTPUT_EN SHALL take priority, and that output SHALL then be recorded as the first sample: MIN=MAX=C_OUT, STAT_VALID=1, SAT_CNT=1 if clamped, else 0.
REQ-033 STAT_CLR SHALL NOT disturb the data pipeline.

Reset
REQ-034 RESET high SHALL immediately force:
 - all valid bits, OUTPUT_EN, C_OUT, SAT_CNT and STAT_VALID to 0;
 - MIN to 2^(DW-1)-1 and MAX to -2^(DW-1).
REQ-035 Samples in flight at reset SHALL be discarded and never produce OUTPUT_EN.
REQ-036 After RESET is released, the first OUTPUT_EN SHALL correspond to the first INPUT_EN sampled after release.

Verification (defaults DW=8, GAIN=0x0100, Q_PARAM=0x0100 unless stated)
REQ-037 Add case: A=10, B=20, OP_SEL=0 at cycle 0 -> OUTPUT_EN at cycle 5 with C_OUT=30; MIN=MAX=30; STAT_VALID=1.
REQ-038 Saturation case: A=100, B=100, add -> C_OUT=127 and SAT_CNT=1. Then A=100, B=-100, subtract -> C_OUT=-128 and SAT_CNT=2.
REQ-039 Rounding case: Q_PARAM=0x0080, B=0, A=1 -> C_OUT=1. A=-1 -> C_OUT=0. A=3 -> C_OUT=2.
REQ-040 Streaming case: 16 back-to-back samples, with GAIN toggling 0x0100/0x0200 every sample -> 16 consecutive OUTPUT_EN cycles, each result matching its own GAIN, and MIN/MAX equal to the reference-model extrema.
REQ-041 Statistics-clear case: STAT_CLR asserted on the same cycle as an output C_OUT=-5 -> MIN=MAX=-5, SAT_CNT=0. Without a coincident output -> MIN=127, MAX=-128, STAT_VALID=0.
REQ-042 Reset-mid-operation case: RESET pulsed at cycle 2 with 3 samples in flight -> no OUTPUT_EN from them, and all outputs at their reset values.

Source files
------------

// File: rtl/q_add_pipe_if.sv
// q_add_pipe_if: sample, control and statistics signals of the q_add_pipe block.
// The master drives samples in; the slave (the pipeline) returns results and statistics.
interface q_add_pipe_if #(
    parameter int DW = 8,
    parameter int GW = 16,
    parameter int QW = 16
);
    logic                 input_en;
    logic                 op_sel;
    logic                 stat_clr;
    logic signed [DW-1:0] a_in;
    logic signed [DW-1:0] b_in;
    logic signed [GW-1:0] gain;
    logic signed [QW-1:0] q_param;

    logic                 output_en;
    logic signed [DW-1:0] c_out;
    logic signed [DW-1:0] min_out;
    logic signed [DW-1:0] max_out;
    logic                 stat_valid;
    logic [15:0]          sat_cnt;

    modport master (
        output input_en, op_sel, stat_clr, a_in, b_in, gain, q_param,
        input  output_en, c_out, min_out, max_out, stat_valid, sat_cnt
    );

    modport slave (
        input  input_en, op_sel, stat_clr, a_in, b_in, gain, q_param,
        output output_en, c_out, min_out, max_out, stat_valid, sat_cnt
    );
endinterface

// File: rtl/q_add_pipe.sv
// q_add_pipe: five-stage pipeline computing sat(round((B*GAIN +/- A<<GFRAC) * Q >> (GFRAC+QFRAC)))
// with running min/max and saturation statistics over the valid outputs.
module q_add_pipe #(
    parameter int DW    = 8,
    parameter int GW    = 16,
    parameter int QW    = 16,
    parameter int GFRAC = 8,
    parameter int QFRAC = 8
) (
    input  logic        clk,
    input  logic        rst,
    q_add_pipe_if.slave bus
);
    localparam int BW = DW + GW;
    localparam int SW = DW + GW + 1;
    localparam int PW = DW + GW + QW + 1;
    localparam int RW = PW + 1;
    localparam int SH = GFRAC + QFRAC;
    localparam logic signed [DW-1:0] DMAX = DW'((2 ** (DW - 1)) - 1);
    localparam logic signed [DW-1:0] DMIN = DW'(-(2 ** (DW - 1)));
    localparam logic signed [RW-1:0] RMAX = RW'(DMAX);
    localparam logic signed [RW-1:0] RMIN = RW'(DMIN);

    logic                 v1_q, v1_d, op1_q, op1_d;
    logic signed [DW-1:0] a1_q, a1_d, b1_q, b1_d;
    logic signed [GW-1:0] g1_q, g1_d;
    logic signed [QW-1:0] q1_q, q1_d;

    logic                 v2_q, v2_d, op2_q, op2_d;
    logic signed [DW-1:0] a2_q, a2_d;
    logic signed [QW-1:0] q2_q, q2_d;
    logic signed [BW-1:0] bg2_q, bg2_d;

    logic                 v3_q, v3_d;
    logic signed [QW-1:0] q3_q, q3_d;
    logic signed [SW-1:0] sum3_q, sum3_d;

    logic                 v4_q, v4_d;
    logic signed [PW-1:0] prod4_q, prod4_d;

    logic                 out_en_q, out_en_d, sat_q, sat_d;
    logic signed [DW-1:0] c_q, c_d;

    logic signed [DW-1:0] min_q, min_d, max_q, max_d;
    logic                 stat_valid_q, stat_valid_d;
    logic [15:0]          sat_cnt_q, sat_cnt_d;

    logic signed [SW-1:0] a_aligned, bg_ext;
    logic signed [RW-1:0] rounded, shifted;

    always_comb begin
        v1_d  = bus.input_en;
        op1_d = bus.op_sel;
        a1_d  = bus.a_in;
        b1_d  = bus.b_in;
        g1_d  = bus.gain;
        q1_d  = bus.q_param;

        v2_d  = v1_q;
        op2_d = op1_q;
        a2_d  = a1_q;
        q2_d  = q1_q;
        bg2_d = b1_q * g1_q;

        a_aligned = SW'(a2_q) <<< GFRAC;
        bg_ext    = SW'(bg2_q);
        v3_d      = v2_q;
        q3_d      = q2_q;
        sum3_d    = op2_q ? (bg_ext - a_aligned) : (bg_ext + a_aligned);

        v4_d    = v3_q;
        prod4_d = PW'(sum3_q) * PW'(q3_q);

        // Round half-up in one extra bit so the bias can never wrap the product.
        rounded  = RW'(prod4_q) + (RW'(1) <<< (SH - 1));
        shifted  = rounded >>> SH;
        out_en_d = v4_q;
        c_d      = c_q;
        sat_d    = sat_q;
        if (v4_q) begin
            if (shifted > RMAX) begin
                c_d   = DMAX;
                sat_d = 1'b1;
            end else if (shifted < RMIN) begin
                c_d   = DMIN;
                sat_d = 1'b1;
            end else begin
                c_d   = shifted[DW-1:0];
                sat_d = 1'b0;
            end
        end
    end

    // Statistics absorb the registered result during its OUTPUT_EN cycle, so a clear
    // raised in that same cycle restarts the statistics with this output as the first sample.
    always_comb begin
        min_d        = min_q;
        max_d        = max_q;
        stat_valid_d = stat_valid_q;
        sat_cnt_d    = sat_cnt_q;
        if (bus.stat_clr) begin
            min_d        = DMAX;
            max_d        = DMIN;
            stat_valid_d = 1'b0;
            sat_cnt_d    = 16'd0;
            if (out_en_q) begin
                min_d        = c_q;
                max_d        = c_q;
                stat_valid_d = 1'b1;
                sat_cnt_d    = {15'd0, sat_q};
            end
        end else if (out_en_q) begin
            if (c_q < min_q) min_d = c_q;
            if (c_q > max_q) max_d = c_q;
            stat_valid_d = 1'b1;
            if (sat_q && (sat_cnt_q != 16'hFFFF)) sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0; op1_q <= 1'b0; a1_q <= '0; b1_q <= '0; g1_q <= '0; q1_q <= '0;
            v2_q <= 1'b0; op2_q <= 1'b0; a2_q <= '0; q2_q <= '0; bg2_q <= '0;
            v3_q <= 1'b0; q3_q <= '0; sum3_q <= '0;
            v4_q <= 1'b0; prod4_q <= '0;
            out_en_q     <= 1'b0;
            sat_q        <= 1'b0;
            c_q          <= '0;
            min_q        <= DMAX;
            max_q        <= DMIN;
            stat_valid_q <= 1'b0;
            sat_cnt_q    <= 16'd0;
        end else begin
            v1_q <= v1_d; op1_q <= op1_d; a1_q <= a1_d; b1_q <= b1_d; g1_q <= g1_d; q1_q <= q1_d;
            v2_q <= v2_d; op2_q <= op2_d; a2_q <= a2_d; q2_q <= q2_d; bg2_q <= bg2_d;
            v3_q <= v3_d; q3_q <= q3_d; sum3_q <= sum3_d;
            v4_q <= v4_d; prod4_q <= prod4_d;
            out_en_q     <= out_en_d;
            sat_q        <= sat_d;
            c_q          <= c_d;
            min_q        <= min_d;
            max_q        <= max_d;
            stat_valid_q <= stat_valid_d;
            sat_cnt_q    <= sat_cnt_d;
        end
    end

    assign bus.output_en  = out_en_q;
    assign bus.c_out      = c_q;
    assign bus.min_out    = min_q;
    assign bus.max_out    = max_q;
    assign bus.stat_valid = stat_valid_q;
    assign bus.sat_cnt    = sat_cnt_q;
endmodule

// File: tb/tb_q_add_pipe.sv
// tb_q_add_pipe: directed stimulus for q_add_pipe, checked every cycle against an
// arithmetic reference model with a queue of expected results and modelled statistics.
module tb_q_add_pipe;
    localparam int DW    = 8;
    localparam int GW    = 16;
    localparam int QW    = 16;
    localparam int GFRAC = 8;
    localparam int QFRAC = 8;
    localparam int CMAX  = 127;
    localparam int CMIN  = -128;

    typedef struct {
        int cyc_due;
        int c;
        bit sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;

    exp_t expq[$];
    int   m_min = CMAX;
    int   m_max = CMIN;
    bit   m_valid = 1'b0;
    int   m_sat = 0;
    int   last_c = 0;

    q_add_pipe_if #(.DW(DW), .GW(GW), .QW(QW)) bus ();

    q_add_pipe #(.DW(DW), .GW(GW), .QW(QW), .GFRAC(GFRAC), .QFRAC(QFRAC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint modelRaw(input int a, input int b, input int g, input int qp, input bit op);
        longint s;
        longint p;
        s = longint'(b) * longint'(g);
        if (op) s = s - longint'(a) * (longint'(1) << GFRAC);
        else    s = s + longint'(a) * (longint'(1) << GFRAC);
        p = s * longint'(qp) + (longint'(1) << (GFRAC + QFRAC - 1));
        return p >>> (GFRAC + QFRAC);
    endfunction

    function automatic int clampC(input longint r);
        if (r > CMAX) return CMAX;
        if (r < CMIN) return CMIN;
        return int'(r);
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input int a, input int b, input int g, input int qp, input bit op);
        longint raw;
        @(posedge clk);
        #1;
        bus.input_en = 1'b1;
        bus.stat_clr = 1'b0;
        bus.a_in     = DW'(a);
        bus.b_in     = DW'(b);
        bus.gain     = GW'(g);
        bus.q_param  = QW'(qp);
        bus.op_sel   = op;
        raw = modelRaw(a, b, g, qp, op);
        expq.push_back('{cyc + 5, clampC(raw), (raw > CMAX) || (raw < CMIN)});
    endtask

    task automatic idleCycle(input bit clr);
        @(posedge clk);
        #1;
        bus.input_en = 1'b0;
        bus.stat_clr = clr;
    endtask

    task automatic resetModel();
        expq.delete();
        m_min   = CMAX;
        m_max   = CMIN;
        m_valid = 1'b0;
        m_sat   = 0;
        last_c  = 0;
    endtask

    // Outputs are checked mid-cycle; the model statistics then absorb this cycle's
    // output and clear request, becoming visible one cycle later like the hardware's.
    always @(negedge clk) begin : compare
        bit   exp_v;
        exp_t e;
        if (mon_on) begin
            checkOutput("min_out", bus.min_out, m_min);
            checkOutput("max_out", bus.max_out, m_max);
            checkOutput("stat_valid", bus.stat_valid, m_valid);
            checkOutput("sat_cnt", bus.sat_cnt, m_sat);
            exp_v = (expq.size() > 0) && (expq[0].cyc_due == cyc);
            checkOutput("output_en", bus.output_en, exp_v);
            if (exp_v) begin
                e = expq.pop_front();
                last_c = e.c;
            end
            checkOutput("c_out", bus.c_out, last_c);
            if (bus.stat_clr) begin
                m_min   = CMAX;
                m_max   = CMIN;
                m_valid = 1'b0;
                m_sat   = 0;
                if (exp_v) begin
                    m_min   = e.c;
                    m_max   = e.c;
                    m_valid = 1'b1;
                    m_sat   = e.sat ? 1 : 0;
                end
            end else if (exp_v) begin
                if (e.c < m_min) m_min = e.c;
                if (e.c > m_max) m_max = e.c;
                m_valid = 1'b1;
                if (e.sat && (m_sat < 65535)) m_sat = m_sat + 1;
            end
        end
    end

    initial begin
        bus.input_en = 1'b0;
        bus.stat_clr = 1'b0;
        bus.op_sel   = 1'b0;
        bus.a_in     = '0;
        bus.b_in     = '0;
        bus.gain     = 16'h0100;
        bus.q_param  = 16'h0100;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_on = 1'b1;

        checkOutput("pin_add", clampC(modelRaw(10, 20, 256, 256, 1'b0)), 30);
        checkOutput("pin_sat_hi", clampC(modelRaw(100, 100, 256, 256, 1'b0)), 127);
        checkOutput("pin_sat_lo", clampC(modelRaw(100, -100, 256, 256, 1'b1)), -128);
        checkOutput("pin_round_p1", clampC(modelRaw(1, 0, 256, 128, 1'b0)), 1);
        checkOutput("pin_round_m1", clampC(modelRaw(-1, 0, 256, 128, 1'b0)), 0);
        checkOutput("pin_round_p3", clampC(modelRaw(3, 0, 256, 128, 1'b0)), 2);

        applyStimulus(10, 20, 256, 256, 1'b0);
        repeat (5) idleCycle(1'b0);
        @(negedge clk);
        checkOutput("add_output_en", bus.output_en, 1);
        checkOutput("add_c_out", bus.c_out, 30);
        idleCycle(1'b0);
        @(negedge clk);
        checkOutput("add_min", bus.min_out, 30);
        checkOutput("add_max", bus.max_out, 30);
        checkOutput("add_stat_valid", bus.stat_valid, 1);

        applyStimulus(100, 100, 256, 256, 1'b0);
        applyStimulus(100, -100, 256, 256, 1'b1);
        repeat (7) idleCycle(1'b0);
        @(negedge clk);
        checkOutput("sat_cnt_two", bus.sat_cnt, 2);
        checkOutput("sat_c_out_low", bus.c_out, -128);

        applyStimulus(1, 0, 256, 128, 1'b0);
        applyStimulus(-1, 0, 256, 128, 1'b0);
        applyStimulus(3, 0, 256, 128, 1'b0);
        repeat (7) idleCycle(1'b0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(i * 7 - 50, 40 - i * 9, (i % 2 == 0) ? 256 : 512, 256, 1'(i % 3 == 0));
        end
        repeat (7) idleCycle(1'b0);

        applyStimulus(0, -5, 256, 256, 1'b0);
        repeat (4) idleCycle(1'b0);
        idleCycle(1'b1);
        idleCycle(1'b0);
        @(negedge clk);
        checkOutput("clr_hit_min", bus.min_out, -5);
        checkOutput("clr_hit_max", bus.max_out, -5);
        checkOutput("clr_hit_sat_cnt", bus.sat_cnt, 0);
        checkOutput("clr_hit_valid", bus.stat_valid, 1);
        idleCycle(1'b1);
        idleCycle(1'b0);
        @(negedge clk);
        checkOutput("clr_min", bus.min_out, 127);
        checkOutput("clr_max", bus.max_out, -128);
        checkOutput("clr_valid", bus.stat_valid, 0);

        applyStimulus(50, 60, 256, 256, 1'b0);
        applyStimulus(-20, 7, 512, 256, 1'b1);
        applyStimulus(5, 5, 256, 256, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.input_en = 1'b0;
        resetModel();
        @(negedge clk);
        checkOutput("rst_output_en", bus.output_en, 0);
        checkOutput("rst_c_out", bus.c_out, 0);
        checkOutput("rst_min", bus.min_out, 127);
        checkOutput("rst_max", bus.max_out, -128);
        checkOutput("rst_sat_cnt", bus.sat_cnt, 0);
        checkOutput("rst_valid", bus.stat_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) idleCycle(1'b0);

        applyStimulus(1, 2, 256, 256, 1'b0);
        repeat (7) idleCycle(1'b0);
        @(negedge clk);
        checkOutput("post_rst_c_out", bus.c_out, 3);
        checkOutput("queue_drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end
endmodule
